// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the parametrised UART core.
package uart_pkg;

   localparam int unsigned OS_RATE   = 16;
   localparam int unsigned OS_MID    = 7;
   localparam int unsigned OS_CNT_W  = 5;
   localparam int unsigned BIT_CNT_W = 4;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_ODD  = 1;
   localparam int unsigned PAR_EVEN = 2;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO with registered head word and flags.
module uart_rx_fifo #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W  = ADDR_W + 1;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] rd_ptr, rd_ptr_n;
   logic [ADDR_W-1:0] wr_ptr, wr_ptr_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [WIDTH-1:0]  dout_n;
   logic              pop_ok, push_ok;

   // A pop frees a slot for a push in the same clock, so full+pop+push never drops.
   always_comb begin
      pop_ok   = pop && !empty;
      push_ok  = push && (!full || pop_ok);
      rd_ptr_n = rd_ptr + ADDR_W'(pop_ok);
      wr_ptr_n = wr_ptr + ADDR_W'(push_ok);
      cnt_n    = cnt + CNT_W'(push_ok) - CNT_W'(pop_ok);
      // Head comes from the incoming word when it lands in the slot about to be read.
      if (push_ok && (wr_ptr == rd_ptr_n)) dout_n = din;
      else                                 dout_n = mem[rd_ptr_n];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         dout   <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         rd_ptr <= rd_ptr_n;
         wr_ptr <= wr_ptr_n;
         cnt    <= cnt_n;
         dout   <= dout_n;
         empty  <= (cnt_n == '0);
         full   <= (cnt_n == CNT_W'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_core.sv
// Single-clock UART: holding-register transmitter, 16x oversampling receiver, RX FIFO.
module uart_core
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 27,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ld_tx_data,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_enable,
   output logic                 tx_out,
   output logic                 tx_empty,
   input  logic                 rx_in,
   input  logic                 rx_enable,
   input  logic                 uld_rx_data,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_empty,
   output logic                 rx_full,
   output logic                 rx_overrun
);

   localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned SHIFT_W = DATA_BITS + 1;
   localparam int unsigned FIFO_W = DATA_BITS + 2;
   localparam logic [OS_CNT_W-1:0]  OS_LAST   = OS_CNT_W'(OS_RATE - 1);
   localparam logic [OS_CNT_W-1:0]  OS_SAMPLE = OS_CNT_W'(OS_MID);
   localparam logic [OS_CNT_W-1:0]  STOP_LAST = OS_CNT_W'(OS_RATE * STOP_BITS - 1);
   localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(DATA_BITS - 1);
   localparam logic PAR_EN  = (PARITY != PAR_NONE);
   localparam logic PAR_INV = (PARITY == PAR_ODD);

   // Oversample tick generator shared by both directions
   logic [DIV_W-1:0] div_cnt;
   logic             os_tick_c;

   assign os_tick_c = (div_cnt == DIV_W'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         div_cnt <= '0;
      else if (os_tick_c) div_cnt <= '0;
      else                div_cnt <= div_cnt + 1'b1;
   end

   // Transmitter
   tx_state_e              tx_state, tx_state_n;
   logic [OS_CNT_W-1:0]    tx_os, tx_os_n;
   logic [BIT_CNT_W-1:0]   tx_bit, tx_bit_n;
   logic [SHIFT_W-1:0]     tx_shift, tx_shift_n;
   logic [DATA_BITS-1:0]   hold, hold_n;
   logic                   tx_out_n, tx_empty_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state <= TX_IDLE;
         tx_os    <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         hold     <= '0;
         tx_out   <= 1'b1;
         tx_empty <= 1'b1;
      end else begin
         tx_state <= tx_state_n;
         tx_os    <= tx_os_n;
         tx_bit   <= tx_bit_n;
         tx_shift <= tx_shift_n;
         hold     <= hold_n;
         tx_out   <= tx_out_n;
         tx_empty <= tx_empty_n;
      end
   end

   // Shift register carries {parity, data} so the parity bit falls out after the payload.
   always_comb begin
      tx_state_n = tx_state;
      tx_os_n    = tx_os;
      tx_bit_n   = tx_bit;
      tx_shift_n = tx_shift;
      hold_n     = hold;
      tx_out_n   = tx_out;
      tx_empty_n = tx_empty;

      if (ld_tx_data && tx_empty) begin
         hold_n     = tx_data;
         tx_empty_n = 1'b0;
      end

      case (tx_state)
         TX_IDLE: begin
            tx_out_n = 1'b1;
            if (os_tick_c && !tx_empty && tx_enable) begin
               tx_shift_n = {(^hold) ^ PAR_INV, hold};
               tx_empty_n = 1'b1;
               tx_os_n    = '0;
               tx_out_n   = 1'b0;
               tx_state_n = TX_START;
            end
         end
         TX_START: begin
            if (os_tick_c) begin
               if (tx_os == OS_LAST) begin
                  tx_os_n    = '0;
                  tx_bit_n   = '0;
                  tx_out_n   = tx_shift[0];
                  tx_state_n = TX_DATA;
               end else begin
                  tx_os_n = tx_os + 1'b1;
               end
            end
         end
         TX_DATA: begin
            if (os_tick_c) begin
               if (tx_os == OS_LAST) begin
                  tx_os_n    = '0;
                  tx_shift_n = tx_shift >> 1;
                  tx_out_n   = tx_shift[1];
                  if (tx_bit == BIT_LAST) begin
                     if (PAR_EN) begin
                        tx_state_n = TX_PARITY;
                     end else begin
                        tx_out_n   = 1'b1;
                        tx_state_n = TX_STOP;
                     end
                  end else begin
                     tx_bit_n = tx_bit + 1'b1;
                  end
               end else begin
                  tx_os_n = tx_os + 1'b1;
               end
            end
         end
         TX_PARITY: begin
            if (os_tick_c) begin
               if (tx_os == OS_LAST) begin
                  tx_os_n    = '0;
                  tx_out_n   = 1'b1;
                  tx_state_n = TX_STOP;
               end else begin
                  tx_os_n = tx_os + 1'b1;
               end
            end
         end
         TX_STOP: begin
            if (os_tick_c) begin
               if (tx_os == STOP_LAST) begin
                  tx_os_n    = '0;
                  tx_state_n = TX_IDLE;
               end else begin
                  tx_os_n = tx_os + 1'b1;
               end
            end
         end
         default: tx_state_n = TX_IDLE;
      endcase
   end

   // Receiver
   rx_state_e              rx_state, rx_state_n;
   logic [OS_CNT_W-1:0]    rx_os, rx_os_n;
   logic [BIT_CNT_W-1:0]   rx_bit, rx_bit_n;
   logic [DATA_BITS-1:0]   rx_shift, rx_shift_n;
   logic                   rx_s1, rx_s2, rx_last, rx_last_n;
   logic                   rx_perr, rx_perr_n, rx_ferr, rx_ferr_n;
   logic                   rx_overrun_n;
   logic                   push_c, pop_ok_c;
   logic [FIFO_W-1:0]      push_word_c, head;

   assign pop_ok_c    = uld_rx_data && !rx_empty;
   assign push_word_c = {rx_shift, rx_perr, rx_ferr | ~rx_s2};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_s1      <= 1'b1;
         rx_s2      <= 1'b1;
         rx_last    <= 1'b1;
         rx_state   <= RX_IDLE;
         rx_os      <= '0;
         rx_bit     <= '0;
         rx_shift   <= '0;
         rx_perr    <= 1'b0;
         rx_ferr    <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         rx_s1      <= rx_in;
         rx_s2      <= rx_s1;
         rx_last    <= rx_last_n;
         rx_state   <= rx_state_n;
         rx_os      <= rx_os_n;
         rx_bit     <= rx_bit_n;
         rx_shift   <= rx_shift_n;
         rx_perr    <= rx_perr_n;
         rx_ferr    <= rx_ferr_n;
         rx_overrun <= rx_overrun_n;
      end
   end

   // Start edges are seen by comparing the line on consecutive os_ticks.
   always_comb begin
      rx_state_n   = rx_state;
      rx_os_n      = rx_os;
      rx_bit_n     = rx_bit;
      rx_shift_n   = rx_shift;
      rx_perr_n    = rx_perr;
      rx_ferr_n    = rx_ferr;
      rx_last_n    = rx_last;
      rx_overrun_n = rx_overrun;
      push_c       = 1'b0;

      if (os_tick_c) rx_last_n = rx_s2;

      case (rx_state)
         RX_IDLE: begin
            if (os_tick_c && rx_enable && rx_last && !rx_s2) begin
               rx_os_n    = '0;
               rx_perr_n  = 1'b0;
               rx_ferr_n  = 1'b0;
               rx_state_n = RX_START;
            end
         end
         RX_START: begin
            if (os_tick_c) begin
               if (rx_os == OS_SAMPLE) begin
                  rx_os_n    = '0;
                  rx_bit_n   = '0;
                  rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
               end else begin
                  rx_os_n = rx_os + 1'b1;
               end
            end
         end
         RX_DATA: begin
            if (os_tick_c) begin
               if (rx_os == OS_LAST) begin
                  rx_os_n    = '0;
                  rx_shift_n = {rx_s2, rx_shift[DATA_BITS-1:1]};
                  if (rx_bit == BIT_LAST) rx_state_n = PAR_EN ? RX_PARITY : RX_STOP;
                  else                    rx_bit_n   = rx_bit + 1'b1;
               end else begin
                  rx_os_n = rx_os + 1'b1;
               end
            end
         end
         RX_PARITY: begin
            if (os_tick_c) begin
               if (rx_os == OS_LAST) begin
                  rx_os_n    = '0;
                  rx_perr_n  = (^rx_shift) ^ rx_s2 ^ PAR_INV;
                  rx_state_n = RX_STOP;
               end else begin
                  rx_os_n = rx_os + 1'b1;
               end
            end
         end
         RX_STOP: begin
            if (os_tick_c) begin
               if ((rx_os[3:0] == 4'hF) && !rx_s2) rx_ferr_n = 1'b1;
               if (rx_os == STOP_LAST) begin
                  rx_os_n    = '0;
                  push_c     = 1'b1;
                  rx_state_n = RX_IDLE;
               end else begin
                  rx_os_n = rx_os + 1'b1;
               end
            end
         end
         default: rx_state_n = RX_IDLE;
      endcase

      if (pop_ok_c)             rx_overrun_n = 1'b0;
      else if (push_c && rx_full) rx_overrun_n = 1'b1;
   end

   uart_rx_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_c),
      .din   (push_word_c),
      .pop   (uld_rx_data),
      .dout  (head),
      .empty (rx_empty),
      .full  (rx_full)
   );

   assign rx_data       = head[FIFO_W-1:2];
   assign rx_parity_err = head[1];
   assign rx_frame_err  = head[0];

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench: 8E1 instance with loopback, plus a 7O2 receive-only instance.
module tb_uart_core;

   localparam int BIT_CLKS = 32;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic       ld_tx_data, tx_enable, tx_out, tx_empty, rx_in, rx_enable, uld_rx_data;
   logic [7:0] tx_data, rx_data;
   logic       rx_parity_err, rx_frame_err, rx_empty, rx_full, rx_overrun;
   logic       loop_en, rx_drv;

   logic       tx_out7, tx_empty7, rx_drv7, uld7;
   logic [6:0] rx_data7;
   logic       rx_perr7, rx_ferr7, rx_empty7, rx_full7, rx_overrun7;

   int n_checks = 0;
   int n_fail   = 0;
   logic [9:0] exp_q[$];

   assign rx_in = loop_en ? tx_out : rx_drv;

   uart_core #(.CLK_DIV(2), .DATA_BITS(8), .PARITY(uart_pkg::PAR_EVEN),
               .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut (
      .clk(clk), .reset(reset), .ld_tx_data(ld_tx_data), .tx_data(tx_data),
      .tx_enable(tx_enable), .tx_out(tx_out), .tx_empty(tx_empty), .rx_in(rx_in),
      .rx_enable(rx_enable), .uld_rx_data(uld_rx_data), .rx_data(rx_data),
      .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_empty(rx_empty),
      .rx_full(rx_full), .rx_overrun(rx_overrun));

   uart_core #(.CLK_DIV(2), .DATA_BITS(7), .PARITY(uart_pkg::PAR_ODD),
               .STOP_BITS(2), .FIFO_DEPTH(2)) u_dut7 (
      .clk(clk), .reset(reset), .ld_tx_data(1'b0), .tx_data(7'h00),
      .tx_enable(1'b0), .tx_out(tx_out7), .tx_empty(tx_empty7), .rx_in(rx_drv7),
      .rx_enable(1'b1), .uld_rx_data(uld7), .rx_data(rx_data7),
      .rx_parity_err(rx_perr7), .rx_frame_err(rx_ferr7), .rx_empty(rx_empty7),
      .rx_full(rx_full7), .rx_overrun(rx_overrun7));

   // Wire images, LSB transmitted first: start, data, parity, stop(s).
   function automatic logic [10:0] frame8(input logic [7:0] d, input logic flip, input logic stop);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      return {stop, 1'((ones % 2) != 0) ^ flip, d, 1'b0};
   endfunction

   function automatic logic [10:0] frame7(input logic [6:0] d, input logic flip, input logic stop2);
      int ones = 0;
      for (int i = 0; i < 7; i++) ones += int'(d[i]);
      return {stop2, 1'b1, 1'((ones % 2) == 0) ^ flip, d, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] f, input bit to7);
      for (int i = 0; i < 11; i++) begin
         if (to7) rx_drv7 = f[i]; else rx_drv = f[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
      if (to7) rx_drv7 = 1'b1; else rx_drv = 1'b1;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic load_word(input logic [7:0] w);
      tx_data = w;
      ld_tx_data = 1'b1;
      @(negedge clk);
      ld_tx_data = 1'b0;
   endtask

   task automatic pop8();
      uld_rx_data = 1'b1;
      @(negedge clk);
      uld_rx_data = 1'b0;
   endtask

   task automatic pop7();
      uld7 = 1'b1;
      @(negedge clk);
      uld7 = 1'b0;
   endtask

   // Waits for the start bit, then checks every clock of the frame on tx_out.
   task automatic check_frame(input logic [7:0] w);
      logic [10:0] f;
      int waited, errs;
      f = frame8(w, 1'b0, 1'b1);
      waited = 0;
      while (tx_out !== 1'b0 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      n_checks++;
      if (tx_out !== 1'b0) begin
         n_fail++;
         $display("FAIL tx_start w=%h: tx_out=%b after %0d clocks, required 0", w, tx_out, waited);
         return;
      end
      n_checks++;
      if (tx_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL tx_empty_at_start: got %b, required 1", tx_empty);
      end
      for (int b = 0; b < 11; b++) begin
         errs = 0;
         for (int c = 0; c < BIT_CLKS; c++) begin
            if (tx_out !== f[b]) errs++;
            @(negedge clk);
         end
         n_checks++;
         if (errs != 0) begin
            n_fail++;
            $display("FAIL tx_bit w=%h bit%0d: wrong on %0d of 32 clocks, required %b", w, b, errs, f[b]);
         end
      end
   endtask

   task automatic test_reset();
      n_checks++;
      if ({tx_out, tx_empty, rx_empty, rx_full, rx_overrun, rx_data, rx_parity_err, rx_frame_err}
          !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset8: out/empty/rxe/full/ovr=%b%b%b%b%b data=%h flags=%b%b, required 11100 00 00",
                  tx_out, tx_empty, rx_empty, rx_full, rx_overrun, rx_data, rx_parity_err, rx_frame_err);
      end
      n_checks++;
      if ({tx_out7, tx_empty7, rx_empty7, rx_full7, rx_overrun7, rx_data7} !== {5'b11100, 7'h00}) begin
         n_fail++;
         $display("FAIL reset7: got %b %h, required 11100 00",
                  {tx_out7, tx_empty7, rx_empty7, rx_full7, rx_overrun7}, rx_data7);
      end
   endtask

   task automatic test_tx_a5();
      load_word(8'hA5);
      n_checks++;
      if (tx_empty !== 1'b0) begin
         n_fail++;
         $display("FAIL tx_empty_after_load: got %b, required 0", tx_empty);
      end
      check_frame(8'hA5);
   endtask

   task automatic test_tx_enable();
      int lows = 0;
      tx_enable = 1'b0;
      load_word(8'h5A);
      repeat (150) begin
         if (tx_out !== 1'b1) lows++;
         @(negedge clk);
      end
      n_checks++;
      if (lows != 0 || tx_empty !== 1'b0) begin
         n_fail++;
         $display("FAIL tx_disabled: %0d low clocks, tx_empty=%b, required 0 and 0", lows, tx_empty);
      end
      load_word(8'hFF);
      tx_enable = 1'b1;
      check_frame(8'h5A);
      lows = 0;
      repeat (100) begin
         if (tx_out !== 1'b1) lows++;
         @(negedge clk);
      end
      n_checks++;
      if (lows != 0 || tx_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL tx_ignored_load: %0d low clocks, tx_empty=%b, required 0 and 1", lows, tx_empty);
      end
   endtask

   task automatic test_loopback();
      logic [7:0] words[4];
      words[0] = 8'h3C;
      words[1] = 8'hFF;
      words[2] = 8'($urandom);
      words[3] = 8'($urandom);
      loop_en = 1'b1;
      foreach (words[i]) begin
         load_word(words[i]);
         check_frame(words[i]);
         exp_q.push_back({words[i], 2'b00});
      end
      repeat (10) @(negedge clk);
      n_checks++;
      if (rx_full !== 1'b1 || rx_overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL loop_full: full=%b overrun=%b, required 1 0", rx_full, rx_overrun);
      end
      while (exp_q.size() > 0) begin
         n_checks++;
         if (rx_empty !== 1'b0 || {rx_data, rx_parity_err, rx_frame_err} !== exp_q[0]) begin
            n_fail++;
            $display("FAIL loop_head: empty=%b word=%h flags=%b%b, required 0 %h %b",
                     rx_empty, rx_data, rx_parity_err, rx_frame_err, exp_q[0][9:2], exp_q[0][1:0]);
         end
         void'(exp_q.pop_front());
         pop8();
      end
      n_checks++;
      if (rx_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL loop_drained: rx_empty=%b, required 1", rx_empty);
      end
      loop_en = 1'b0;
   endtask

   task automatic test_glitch();
      int len, bad;
      for (int g = 0; g < 3; g++) begin
         len = (g == 0) ? 10 : int'($urandom_range(12, 4));
         rx_drv = 1'b0;
         repeat (len) @(negedge clk);
         rx_drv = 1'b1;
         bad = 0;
         repeat (400) begin
            if (rx_empty !== 1'b1) bad++;
            @(negedge clk);
         end
         n_checks++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL glitch len=%0d: rx_empty low on %0d clocks, required 0", len, bad);
         end
      end
   endtask

   task automatic test_errors8();
      logic [7:0] w1, w2;
      w1 = 8'($urandom);
      w2 = 8'($urandom);
      send_bits(frame8(w1, 1'b0, 1'b0), 1'b0);
      send_bits(frame8(w2, 1'b1, 1'b1), 1'b0);
      exp_q.push_back({w1, 2'b01});
      exp_q.push_back({w2, 2'b10});
      while (exp_q.size() > 0) begin
         n_checks++;
         if (rx_empty !== 1'b0 || {rx_data, rx_parity_err, rx_frame_err} !== exp_q[0]) begin
            n_fail++;
            $display("FAIL err8_head: empty=%b word=%h perr=%b ferr=%b, required 0 %h %b",
                     rx_empty, rx_data, rx_parity_err, rx_frame_err, exp_q[0][9:2], exp_q[0][1:0]);
         end
         void'(exp_q.pop_front());
         pop8();
      end
   endtask

   task automatic test_errors7();
      logic [6:0] w[3];
      logic [1:0] fl[3];
      foreach (w[i]) w[i] = 7'($urandom);
      fl[0] = 2'b10;
      fl[1] = 2'b01;
      fl[2] = 2'b00;
      send_bits(frame7(w[0], 1'b1, 1'b1), 1'b1);
      send_bits(frame7(w[1], 1'b0, 1'b0), 1'b1);
      n_checks++;
      if (rx_full7 !== 1'b1 || rx_overrun7 !== 1'b0) begin
         n_fail++;
         $display("FAIL err7_full: full=%b overrun=%b, required 1 0", rx_full7, rx_overrun7);
      end
      for (int i = 0; i < 3; i++) begin
         if (i == 2) send_bits(frame7(w[2], 1'b0, 1'b1), 1'b1);
         n_checks++;
         if (rx_empty7 !== 1'b0 || {rx_data7, rx_perr7, rx_ferr7} !== {w[i], fl[i]}) begin
            n_fail++;
            $display("FAIL err7_head%0d: empty=%b word=%h flags=%b%b, required 0 %h %b",
                     i, rx_empty7, rx_data7, rx_perr7, rx_ferr7, w[i], fl[i]);
         end
         pop7();
      end
   endtask

   task automatic test_overrun();
      logic [7:0] w;
      for (int i = 0; i < 5; i++) begin
         w = 8'($urandom);
         send_bits(frame8(w, 1'b0, 1'b1), 1'b0);
         if (i < 4) exp_q.push_back({w, 2'b00});
      end
      n_checks++;
      if (rx_full !== 1'b1 || rx_overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL ovr_flags: full=%b overrun=%b, required 1 1", rx_full, rx_overrun);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (rx_empty !== 1'b0 || {rx_data, rx_parity_err, rx_frame_err} !== exp_q[0]) begin
            n_fail++;
            $display("FAIL ovr_head%0d: empty=%b word=%h flags=%b%b, required 0 %h %b",
                     i, rx_empty, rx_data, rx_parity_err, rx_frame_err, exp_q[0][9:2], exp_q[0][1:0]);
         end
         void'(exp_q.pop_front());
         pop8();
         if (i == 0) begin
            n_checks++;
            if (rx_overrun !== 1'b0 || rx_full !== 1'b0) begin
               n_fail++;
               $display("FAIL ovr_clear: overrun=%b full=%b, required 0 0", rx_overrun, rx_full);
            end
         end
      end
      n_checks++;
      if (rx_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL ovr_drained: rx_empty=%b, required 1", rx_empty);
      end
   endtask

   task automatic test_reset_mid_tx();
      int waited = 0;
      int lows = 0;
      logic [7:0] w;
      load_word(8'h00);
      while (tx_out !== 1'b0 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      repeat (3 * BIT_CLKS) @(negedge clk);
      load_word(8'hC3);
      n_checks++;
      if (tx_out !== 1'b0 || tx_empty !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_tx_pre: tx_out=%b tx_empty=%b, required 0 0", tx_out, tx_empty);
      end
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (tx_out !== 1'b1 || tx_empty !== 1'b1 || rx_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL async_reset: tx_out=%b tx_empty=%b rx_empty=%b, required 1 1 1",
                  tx_out, tx_empty, rx_empty);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      w = 8'($urandom);
      load_word(w);
      check_frame(w);
      repeat (100) begin
         if (tx_out !== 1'b1) lows++;
         @(negedge clk);
      end
      n_checks++;
      if (lows != 0 || tx_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_idle: %0d low clocks, tx_empty=%b, required 0 1", lows, tx_empty);
      end
   endtask

   initial begin
      ld_tx_data  = 1'b0;
      tx_data     = 8'h00;
      tx_enable   = 1'b1;
      rx_enable   = 1'b1;
      uld_rx_data = 1'b0;
      uld7        = 1'b0;
      loop_en     = 1'b0;
      rx_drv      = 1'b1;
      rx_drv7     = 1'b1;
      repeat (3) @(negedge clk);
      test_reset();
      reset = 1'b1;
      repeat (5) @(negedge clk);
      test_tx_a5();
      test_tx_enable();
      test_loopback();
      test_glitch();
      test_errors8();
      test_errors7();
      test_overrun();
      test_reset_mid_tx();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
